// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline front end: instruction field layout,
// ALU op codes, the halt opcode and the fetch/decode state encoding.
package pipe_pkg;

  localparam int DEF_IW        = 24;
  localparam int DEF_PCW       = 8;
  localparam int DEF_HAZ_DEPTH = 2;

  localparam int FUNC_W = 4;
  localparam int REG_W  = 4;
  localparam int ADDR_W = 8;

  localparam int FUNC_LSB = 20;
  localparam int RD_LSB   = 16;
  localparam int RS1_LSB  = 12;
  localparam int RS2_LSB  = 8;
  localparam int ADDR_LSB = 0;

  localparam logic [FUNC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [FUNC_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_LD   = 4'd10,
    OP_ST   = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  // Split a raw instruction word into its named fields.
  function automatic instr_t decode_word(input logic [DEF_IW-1:0] w);
    instr_t f;
    f.func = w[FUNC_LSB +: FUNC_W];
    f.rd   = w[RD_LSB   +: REG_W];
    f.rs1  = w[RS1_LSB  +: REG_W];
    f.rs2  = w[RS2_LSB  +: REG_W];
    f.addr = w[ADDR_LSB +: ADDR_W];
    return f;
  endfunction

endpackage

// File: rtl/pipe_imem.sv
// Instruction memory: 2**PCW words of IW bits, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module pipe_imem #(
  parameter int IW  = 24,
  parameter int PCW = 8
) (
  input  logic           clk,
  input  logic           we,
  input  logic [PCW-1:0] waddr,
  input  logic [IW-1:0]  wdata,
  input  logic [PCW-1:0] raddr,
  output logic [IW-1:0]  rdata
);

  logic [IW-1:0] mem_q [2**PCW];

  // Write port: one word per clock when enabled.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_fetch_decode.sv
// Fetch/decode front end: runs a PC through the instruction memory, decodes
// each word and presents it downstream with a valid/ready handshake until an
// HLT opcode is reached.
// Optional feature macro: PIPE_HAZARD_STALL_EN (RAW hazard bubble insertion).
module pipe_fetch_decode
  import pipe_pkg::*;
#(
  parameter int IW  = DEF_IW,
  parameter int PCW = DEF_PCW
`ifdef PIPE_HAZARD_STALL_EN
  ,
  parameter int HAZ_DEPTH = DEF_HAZ_DEPTH
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_en,
  input  logic [PCW-1:0] load_addr,
  input  logic [IW-1:0]  load_data,
  input  logic           start,
  input  logic [PCW-1:0] start_pc,
  input  logic           abort,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [3:0]     rs1,
  output logic [3:0]     rs2,
  output logic [3:0]     rd,
  output logic [3:0]     func,
  output logic [7:0]     addr,
  output logic [PCW-1:0] pc,
  output logic           halted,
  output logic [15:0]    issue_cnt
);

  state_e         state_q, state_d;
  logic           out_valid_q, out_valid_d;
  instr_t         fields_q, fields_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [15:0]    issue_cnt_q, issue_cnt_d;

  logic [IW-1:0]  imem_rdata;
  logic           imem_we;
  instr_t         cand;
  logic           slot_free;
  logic           hazard_stall;

  // Loads are only allowed while no program is running.
  assign imem_we = load_en && (state_q != ST_RUN);

  pipe_imem #(
    .IW  (IW),
    .PCW (PCW)
  ) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_q),
    .rdata (imem_rdata)
  );

  assign cand      = decode_word(imem_rdata);
  assign slot_free = !out_valid_q || out_ready;

`ifdef PIPE_HAZARD_STALL_EN
  logic [HAZ_DEPTH-1:0]            haz_vld_q, haz_vld_d;
  logic [HAZ_DEPTH-1:0][REG_W-1:0] haz_rd_q, haz_rd_d;
  logic                            issue_now;

  assign issue_now = (state_q == ST_RUN) && !abort && slot_free &&
                     (cand.func != OP_HLT) && !hazard_stall;

  // Flag a bubble when a source register is still being produced in flight.
  always_comb begin
    hazard_stall = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (haz_vld_q[i] && ((haz_rd_q[i] == cand.rs1) || (haz_rd_q[i] == cand.rs2)))
        hazard_stall = 1'b1;
    end
  end

  // Age the destination tracker; an issue always records its rd even into an empty slot.
  always_comb begin
    haz_vld_d = haz_vld_q;
    haz_rd_d  = haz_rd_q;
    if (abort || (state_q != ST_RUN) || (slot_free && (cand.func == OP_HLT))) begin
      haz_vld_d = '0;
    end else if (out_ready || issue_now) begin
      for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
        haz_vld_d[i] = haz_vld_q[i-1];
        haz_rd_d[i]  = haz_rd_q[i-1];
      end
      haz_vld_d[0] = issue_now;
      haz_rd_d[0]  = cand.rd;
    end
  end

  // Tracker registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      haz_vld_q <= '0;
      haz_rd_q  <= '0;
    end else begin
      haz_vld_q <= haz_vld_d;
      haz_rd_q  <= haz_rd_d;
    end
  end
`else
  assign hazard_stall = 1'b0;
`endif

  // Next-state logic: fetch rule in RUN, start handling, abort override.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    fields_d    = fields_q;
    pc_d        = pc_q;
    issue_cnt_d = issue_cnt_q;

    if (out_valid_q && out_ready) issue_cnt_d = issue_cnt_q + 16'd1;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = start_pc;
        end
      end
      ST_RUN: begin
        if (slot_free) begin
          if (cand.func == OP_HLT) begin
            out_valid_d = 1'b0;
            state_d     = ST_HALT;
          end else if (hazard_stall) begin
            out_valid_d = 1'b0;
          end else begin
            fields_d    = cand;
            out_valid_d = 1'b1;
            pc_d        = pc_q + PCW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      fields_d    = fields_q;
      pc_d        = pc_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      fields_q    <= '0;
      pc_q        <= '0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      fields_q    <= fields_d;
      pc_q        <= pc_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign func      = fields_q.func;
  assign rd        = fields_q.rd;
  assign rs1       = fields_q.rs1;
  assign rs2       = fields_q.rs2;
  assign addr      = fields_q.addr;
  assign pc        = pc_q;
  assign halted    = (state_q == ST_HALT);
  assign issue_cnt = issue_cnt_q;

endmodule
